writeback_stage: RTL and testbench

//  Final pipeline stage, directly upstream of the register file write port. Accepts

---
 rtl/writeback_stage.sv | 169 ++++++++++++++++
 tb/tb_writeback_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Brief    : Final pipeline stage ahead of the register-file write port.
//            ALU results retire one cycle after acceptance. Loads wait for the
//            data-memory response and then retire with the loaded data.
//            Also provides a retire counter and a sticky spurious-response flag.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_reg_write,
    input  logic [ADDR_WIDTH-1:0] in_reg_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_ps_write,
    input  logic                  in_ps_data,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [ADDR_WIDTH-1:0] wb_reg_addr,
    output logic [DATA_WIDTH-1:0] wb_reg_data,
    output logic                  wb_ps_write,
    output logic                  wb_ps_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  retire_count,
    output logic                  err_spurious
);

    localparam logic [0:0]           c_st_idle     = 1'b0;
    localparam logic [0:0]           c_st_wait_mem = 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;

    // Destination fields of the load currently waiting for memory
    logic                  r_cap_reg_write;
    logic [ADDR_WIDTH-1:0] r_cap_reg_addr;
    logic                  r_cap_ps_write;
    logic                  r_cap_ps_data;
    logic                  w_cap_reg_write_nxt;
    logic [ADDR_WIDTH-1:0] w_cap_reg_addr_nxt;
    logic                  w_cap_ps_write_nxt;
    logic                  w_cap_ps_data_nxt;

    logic                  r_wb_valid;
    logic                  r_wb_reg_write;
    logic [ADDR_WIDTH-1:0] r_wb_reg_addr;
    logic [DATA_WIDTH-1:0] r_wb_reg_data;
    logic                  r_wb_ps_write;
    logic                  r_wb_ps_data;
    logic                  w_wb_valid_nxt;
    logic                  w_wb_reg_write_nxt;
    logic [ADDR_WIDTH-1:0] w_wb_reg_addr_nxt;
    logic [DATA_WIDTH-1:0] w_wb_reg_data_nxt;
    logic                  w_wb_ps_write_nxt;
    logic                  w_wb_ps_data_nxt;

    logic [CNT_WIDTH-1:0]  r_retire_count;
    logic                  r_err_spurious;
    logic                  w_err_spurious_nxt;

    logic                  w_accept;

    // Ready depends on state alone so upstream sees no combinational loop
    assign in_ready = (r_state == c_st_idle);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_state_nxt         = r_state;
        w_cap_reg_write_nxt = r_cap_reg_write;
        w_cap_reg_addr_nxt  = r_cap_reg_addr;
        w_cap_ps_write_nxt  = r_cap_ps_write;
        w_cap_ps_data_nxt   = r_cap_ps_data;
        w_wb_valid_nxt      = 1'b0;
        w_wb_reg_write_nxt  = 1'b0;
        w_wb_reg_addr_nxt   = '0;
        w_wb_reg_data_nxt   = '0;
        w_wb_ps_write_nxt   = 1'b0;
        w_wb_ps_data_nxt    = 1'b0;
        w_err_spurious_nxt  = r_err_spurious;

        if (r_state == c_st_idle) begin
            // A response with nothing outstanding is dropped but remembered
            if (mem_rsp_valid) begin
                w_err_spurious_nxt = 1'b1;
            end
            if (w_accept) begin
                if (in_is_load) begin
                    w_state_nxt         = c_st_wait_mem;
                    w_cap_reg_write_nxt = in_reg_write;
                    w_cap_reg_addr_nxt  = in_reg_addr;
                    w_cap_ps_write_nxt  = in_ps_write;
                    w_cap_ps_data_nxt   = in_ps_data;
                end else begin
                    w_wb_valid_nxt     = 1'b1;
                    w_wb_reg_write_nxt = in_reg_write;
                    w_wb_reg_addr_nxt  = in_reg_addr;
                    w_wb_reg_data_nxt  = in_data;
                    w_wb_ps_write_nxt  = in_ps_write;
                    w_wb_ps_data_nxt   = in_ps_data;
                end
            end
        end else if (mem_rsp_valid) begin
            w_state_nxt        = c_st_idle;
            w_wb_valid_nxt     = 1'b1;
            w_wb_reg_write_nxt = r_cap_reg_write;
            w_wb_reg_addr_nxt  = r_cap_reg_addr;
            w_wb_reg_data_nxt  = mem_rsp_data;
            w_wb_ps_write_nxt  = r_cap_ps_write;
            w_wb_ps_data_nxt   = r_cap_ps_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_st_idle;
            r_cap_reg_write <= 1'b0;
            r_cap_reg_addr  <= '0;
            r_cap_ps_write  <= 1'b0;
            r_cap_ps_data   <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_reg_addr   <= '0;
            r_wb_reg_data   <= '0;
            r_wb_ps_write   <= 1'b0;
            r_wb_ps_data    <= 1'b0;
            r_retire_count  <= '0;
            r_err_spurious  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cap_reg_write <= w_cap_reg_write_nxt;
            r_cap_reg_addr  <= w_cap_reg_addr_nxt;
            r_cap_ps_write  <= w_cap_ps_write_nxt;
            r_cap_ps_data   <= w_cap_ps_data_nxt;
            r_wb_valid      <= w_wb_valid_nxt;
            r_wb_reg_write  <= w_wb_reg_write_nxt;
            r_wb_reg_addr   <= w_wb_reg_addr_nxt;
            r_wb_reg_data   <= w_wb_reg_data_nxt;
            r_wb_ps_write   <= w_wb_ps_write_nxt;
            r_wb_ps_data    <= w_wb_ps_data_nxt;
            r_err_spurious  <= w_err_spurious_nxt;
            if (r_wb_valid) begin
                r_retire_count <= r_retire_count + c_cnt_one;
            end
        end
    end

    assign wb_valid     = r_wb_valid;
    assign wb_reg_write = r_wb_reg_write;
    assign wb_reg_addr  = r_wb_reg_addr;
    assign wb_reg_data  = r_wb_reg_data;
    assign wb_ps_write  = r_wb_ps_write;
    assign wb_ps_data   = r_wb_ps_data;
    assign busy         = (r_state == c_st_wait_mem);
    assign retire_count = r_retire_count;
    assign err_spurious = r_err_spurious;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Self-checking bench for writeback_stage: directed vector table,
//            hand-written reset/back-to-back sequences and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_is_load, in_reg_write;
    logic [AW-1:0] in_reg_addr;
    logic [DW-1:0] in_data;
    logic          in_ps_write, in_ps_data;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          wb_valid, wb_reg_write;
    logic [AW-1:0] wb_reg_addr;
    logic [DW-1:0] wb_reg_data;
    logic          wb_ps_write, wb_ps_data, busy, err_spurious;
    logic [CW-1:0] retire_count;

    always #5 clk = ~clk;

    writeback_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
        .in_reg_write(in_reg_write), .in_reg_addr(in_reg_addr), .in_data(in_data),
        .in_ps_write(in_ps_write), .in_ps_data(in_ps_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg_addr(wb_reg_addr),
        .wb_reg_data(wb_reg_data), .wb_ps_write(wb_ps_write), .wb_ps_data(wb_ps_data),
        .busy(busy), .retire_count(retire_count), .err_spurious(err_spurious)
    );

    typedef struct {
        logic          valid, is_load, rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          psw, psd, rsp_v;
        logic [DW-1:0] rsp_d;
    } stim_t;

    typedef struct {
        logic          valid, rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          psw, psd, busy, ready, err;
        logic [CW-1:0] count;
    } obs_t;

    typedef struct {
        stim_t s;
        obs_t  e;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: a pending-load slot plus running totals
    bit    m_wait;
    stim_t m_cap;
    obs_t  m_exp;
    logic [CW-1:0] m_count;
    bit    m_err;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{valid: 1'b0, is_load: 1'b0, rw: 1'b0, addr: '0, data: '0,
              psw: 1'b0, psd: 1'b0, rsp_v: 1'b0, rsp_d: '0};
        return s;
    endfunction

    function automatic obs_t zero_obs();
        obs_t o;
        o = '{valid: 1'b0, rw: 1'b0, addr: '0, data: '0, psw: 1'b0, psd: 1'b0,
              busy: 1'b0, ready: 1'b1, err: 1'b0, count: '0};
        return o;
    endfunction

    task automatic model_reset();
        m_wait  = 1'b0;
        m_cap   = idle_stim();
        m_count = '0;
        m_err   = 1'b0;
        m_exp   = zero_obs();
    endtask

    task automatic model_step(input stim_t s);
        obs_t e;
        e = zero_obs();
        if (m_exp.valid) m_count = m_count + 32'd1;
        if (!m_wait) begin
            if (s.rsp_v) m_err = 1'b1;
            if (s.valid) begin
                if (s.is_load) begin
                    m_wait = 1'b1;
                    m_cap  = s;
                end else begin
                    e.valid = 1'b1; e.rw = s.rw; e.addr = s.addr; e.data = s.data;
                    e.psw = s.psw; e.psd = s.psd;
                end
            end
        end else if (s.rsp_v) begin
            e.valid = 1'b1; e.rw = m_cap.rw; e.addr = m_cap.addr; e.data = s.rsp_d;
            e.psw = m_cap.psw; e.psd = m_cap.psd;
            m_wait = 1'b0;
        end
        e.busy  = m_wait;
        e.ready = !m_wait;
        e.err   = m_err;
        e.count = m_count;
        m_exp   = e;
    endtask

    task automatic drive(input stim_t s);
        in_valid      = s.valid;
        in_is_load    = s.is_load;
        in_reg_write  = s.rw;
        in_reg_addr   = s.addr;
        in_data       = s.data;
        in_ps_write   = s.psw;
        in_ps_data    = s.psd;
        mem_rsp_valid = s.rsp_v;
        mem_rsp_data  = s.rsp_d;
    endtask

    // Drive one cycle, advance the model, and land 1 time unit after the edge
    task automatic cycle(input stim_t s);
        drive(s);
        model_step(s);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_obs(input string tag, input obs_t e);
        chk({tag, ".wb_valid"},     32'(wb_valid),     32'(e.valid));
        chk({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'(e.rw));
        chk({tag, ".wb_reg_addr"},  32'(wb_reg_addr),  32'(e.addr));
        chk({tag, ".wb_reg_data"},  32'(wb_reg_data),  32'(e.data));
        chk({tag, ".wb_ps_write"},  32'(wb_ps_write),  32'(e.psw));
        chk({tag, ".wb_ps_data"},   32'(wb_ps_data),   32'(e.psd));
        chk({tag, ".busy"},         32'(busy),         32'(e.busy));
        chk({tag, ".in_ready"},     32'(in_ready),     32'(e.ready));
        chk({tag, ".err_spurious"}, 32'(err_spurious), 32'(e.err));
        chk({tag, ".retire_count"}, retire_count,      e.count);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_obs(tag, m_exp);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic stim_t mk(input logic v, input logic ld, input logic rw,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic psw, input logic psd,
                                 input logic rv, input logic [DW-1:0] rd);
        stim_t s;
        s = '{valid: v, is_load: ld, rw: rw, addr: a, data: d,
              psw: psw, psd: psd, rsp_v: rv, rsp_d: rd};
        return s;
    endfunction

    function automatic obs_t ex(input logic v, input logic rw, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic psw, input logic psd,
                                input logic bz);
        obs_t o;
        o = '{valid: v, rw: rw, addr: a, data: d, psw: psw, psd: psd,
              busy: bz, ready: !bz, err: 1'b0, count: '0};
        return o;
    endfunction

    vec_t vecs[12];

    initial begin
        obs_t  e;
        stim_t s;

        // valid, load, rw, addr, data, psw, psd, rsp_v, rsp_d  ->  expected after edge
        vecs[0]  = '{mk(1,0,1,4'd3,16'h1234,0,0,0,16'h0),    ex(1,1,4'd3,16'h1234,0,0,0)};
        vecs[1]  = '{mk(0,0,0,4'd0,16'h0,0,0,0,16'h0),       ex(0,0,4'd0,16'h0,0,0,0)};
        vecs[2]  = '{mk(1,0,0,4'd7,16'h5555,1,1,0,16'h0),    ex(1,0,4'd7,16'h5555,1,1,0)};
        vecs[3]  = '{mk(1,1,1,4'd5,16'hAAAA,0,0,0,16'h0),    ex(0,0,4'd0,16'h0,0,0,1)};
        vecs[4]  = '{mk(1,0,1,4'd9,16'h0909,0,0,0,16'h0),    ex(0,0,4'd0,16'h0,0,0,1)};
        vecs[5]  = '{mk(1,0,1,4'd9,16'h0909,0,0,0,16'h0),    ex(0,0,4'd0,16'h0,0,0,1)};
        vecs[6]  = '{mk(1,0,1,4'd9,16'h0909,0,0,1,16'hBEEF), ex(1,1,4'd5,16'hBEEF,0,0,0)};
        vecs[7]  = '{mk(1,0,1,4'd9,16'h0909,0,0,0,16'h0),    ex(1,1,4'd9,16'h0909,0,0,0)};
        vecs[8]  = '{mk(0,0,0,4'd0,16'h0,0,0,0,16'h0),       ex(0,0,4'd0,16'h0,0,0,0)};
        vecs[9]  = '{mk(1,1,0,4'd2,16'h0,1,0,0,16'h0),       ex(0,0,4'd0,16'h0,0,0,1)};
        vecs[10] = '{mk(0,0,0,4'd0,16'h0,0,0,1,16'h1111),    ex(1,0,4'd2,16'h1111,1,0,0)};
        vecs[11] = '{mk(0,0,0,4'd0,16'h0,0,0,0,16'h0),       ex(0,0,4'd0,16'h0,0,0,0)};

        drive(idle_stim());
        apply_reset("reset");

        // Directed table: ALU op, ps-only op, load with 3-cycle wait, accept on retire edge
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].s);
            e       = vecs[i].e;
            e.err   = 1'b0;
            e.count = m_count;
            check_obs($sformatf("vec%0d", i), e);
        end
        chk("table_retire_count", retire_count, 32'd5);

        // Four back-to-back ALU ops from a fresh reset
        apply_reset("reset2");
        for (int i = 0; i < 4; i++) begin
            cycle(mk(1, 0, 1, 4'(i + 1), 16'(16'hC000 + i), 0, 0, 0, 16'h0));
            check_obs($sformatf("b2b%0d", i), m_exp);
        end
        cycle(idle_stim());
        check_obs("b2b_tail", m_exp);
        chk("b2b_count", retire_count, 32'd4);

        // Reset while waiting on memory, then a stray response
        cycle(mk(1, 1, 1, 4'd6, 16'h0, 0, 0, 0, 16'h0));
        check_obs("rstwait_load", m_exp);
        cycle(idle_stim());
        rst = 1'b1;
        #2;
        chk("rstwait_async_busy", 32'(busy), 32'd0);
        chk("rstwait_async_valid", 32'(wb_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(mk(0, 0, 0, 4'd0, 16'h0, 0, 0, 1, 16'hDEAD));
        check_obs("rstwait_rsp", m_exp);
        chk("rstwait_err", 32'(err_spurious), 32'd1);
        cycle(idle_stim());
        check_obs("rstwait_after", m_exp);

        // Randomized traffic against the model
        apply_reset("reset3");
        for (int i = 0; i < 400; i++) begin
            s.valid   = ($urandom_range(0, 99) < 60);
            s.is_load = ($urandom_range(0, 99) < 35);
            s.rw      = 1'($urandom);
            s.addr    = 4'($urandom);
            s.data    = 16'($urandom);
            s.psw     = 1'($urandom);
            s.psd     = 1'($urandom);
            s.rsp_v   = m_wait ? ($urandom_range(0, 99) < 35)
                               : (i > 300 && $urandom_range(0, 99) < 5);
            s.rsp_d   = 16'($urandom);
            cycle(s);
            check_obs($sformatf("rand%0d", i), m_exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
